// File: rtl/disp_scan_if.sv
// Host/decoder-side bus of the eight-digit multiplexed display scanner.
// The scanner takes the slave modport and the host takes the master modport.
interface disp_scan_if;
   logic        load;
   logic [31:0] data;
   logic [7:0]  points;
   logic [7:0]  blank;
   logic        lz_en;
   logic [7:0]  an;
   logic [3:0]  hex;
   logic        le;
   logic        point;
   logic        pending;
   logic        frame_done;

   modport master (
      output load, data, points, blank, lz_en,
      input  an, hex, le, point, pending, frame_done
   );

   modport slave (
      input  load, data, points, blank, lz_en,
      output an, hex, le, point, pending, frame_done
   );
endinterface

// File: rtl/disp_scan.sv
// Eight-digit time-multiplexed hex display scanner with double-buffered data,
// frame-synchronous commit, per-digit blanking and leading-zero suppression.
module disp_scan #(
   parameter int unsigned SCAN_DIV = 100000,
   parameter int unsigned GUARD    = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   disp_scan_if.slave bus
);
   localparam int unsigned   CW      = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   pend_data_q, pend_data_d;
   logic [7:0]    pend_points_q, pend_points_d;
   logic [7:0]    pend_blank_q, pend_blank_d;
   logic          pending_q, pending_d;
   logic [31:0]   act_data_q, act_data_d;
   logic [7:0]    act_points_q, act_points_d;
   logic [7:0]    act_blank_q, act_blank_d;
   logic [7:0]    an_q, an_d;
   logic [3:0]    hex_q, hex_d;
   logic          le_q, le_d;
   logic          point_q, point_d;
   logic          fd_q, fd_d;

   logic cnt_wrap, commit, in_guard, suppress, dark;

   always_comb begin
      cnt_wrap = (cnt_q == CNT_MAX);
      commit   = cnt_wrap && (idx_q == 3'd7);
      cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);
      idx_d    = cnt_wrap ? idx_q + 3'd1 : idx_q;

      pend_data_d   = pend_data_q;
      pend_points_d = pend_points_q;
      pend_blank_d  = pend_blank_q;
      pending_d     = pending_q;
      act_data_d    = act_data_q;
      act_points_d  = act_points_q;
      act_blank_d   = act_blank_q;

      // Commit of the old pending value happens before a coincident load is captured.
      if (commit) begin
         if (pending_q) begin
            act_data_d   = pend_data_q;
            act_points_d = pend_points_q;
            act_blank_d  = pend_blank_q;
         end
         pending_d = 1'b0;
      end
      if (bus.load) begin
         pend_data_d   = bus.data;
         pend_points_d = bus.points;
         pend_blank_d  = bus.blank;
         pending_d     = 1'b1;
      end

      // A digit is a leading zero when it and every more significant nibble are zero.
      suppress = bus.lz_en && (idx_q != 3'd0);
      for (int k = 0; k < 8; k++) begin
         if ((k >= int'(idx_q)) && (act_data_q[4*k +: 4] != 4'd0)) begin
            suppress = 1'b0;
         end
      end

      in_guard = (cnt_q < GUARD_C);
      dark     = act_blank_q[idx_q] || suppress;
      an_d     = in_guard ? 8'hFF : ~(8'd1 << idx_q);
      hex_d    = act_data_q[{idx_q, 2'b00} +: 4];
      le_d     = in_guard || dark;
      point_d  = !in_guard && !dark && act_points_q[idx_q];
      fd_d     = commit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         idx_q         <= 3'd0;
         pend_data_q   <= 32'd0;
         pend_points_q <= 8'd0;
         pend_blank_q  <= 8'd0;
         pending_q     <= 1'b0;
         act_data_q    <= 32'd0;
         act_points_q  <= 8'd0;
         act_blank_q   <= 8'd0;
         an_q          <= 8'hFF;
         hex_q         <= 4'd0;
         le_q          <= 1'b1;
         point_q       <= 1'b0;
         fd_q          <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         pend_data_q   <= pend_data_d;
         pend_points_q <= pend_points_d;
         pend_blank_q  <= pend_blank_d;
         pending_q     <= pending_d;
         act_data_q    <= act_data_d;
         act_points_q  <= act_points_d;
         act_blank_q   <= act_blank_d;
         an_q          <= an_d;
         hex_q         <= hex_d;
         le_q          <= le_d;
         point_q       <= point_d;
         fd_q          <= fd_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.hex        = hex_q;
   assign bus.le         = le_q;
   assign bus.point      = point_q;
   assign bus.pending    = pending_q;
   assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan: a cycle-count-based reference model queues the
// expected registered outputs, and a negedge monitor pops and compares them.
module tb_disp_scan;
   localparam int SD    = 4;
   localparam int GD    = 1;
   localparam int FRAME = 8 * SD;

   typedef struct packed {
      logic [7:0] an;
      logic [3:0] hex;
      logic       le;
      logic       point;
      logic       pending;
      logic       fd;
   } outs_t;

   logic clk = 1'b0;
   logic rst_n;
   disp_scan_if bus();

   disp_scan #(.SCAN_DIV(SD), .GUARD(GD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   outs_t exp_q[$];

   // Reference state: cycles since reset release, plus the two register banks.
   int          tm;
   logic [31:0] m_pdata, m_adata;
   logic [7:0]  m_ppts, m_apts, m_pblk, m_ablk;
   logic        m_pend;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
   endtask

   task automatic model_clear();
      tm = 0;
      m_pdata = '0; m_adata = '0;
      m_ppts = '0; m_apts = '0; m_pblk = '0; m_ablk = '0;
      m_pend = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_step();
      int pos, slot, sig;
      logic lit, guard;
      outs_t e;
      pos  = tm % SD;
      slot = (tm / SD) % 8;
      // Significant digit count: highest nonzero nibble position + 1, at least 1.
      sig = 1;
      for (int k = 1; k < 8; k++) if (((m_adata >> (4 * k)) & 32'hF) != 0) sig = k + 1;
      lit     = !m_ablk[slot] && (!bus.lz_en || slot < sig);
      guard   = pos < GD;
      e.an    = guard ? 8'hFF : ~(8'h01 << slot);
      e.hex   = 4'((m_adata >> (4 * slot)) & 32'hF);
      e.le    = guard || !lit;
      e.point = !guard && lit && m_apts[slot];
      e.fd    = (tm % FRAME) == FRAME - 1;
      if (e.fd) begin
         if (m_pend) begin
            m_adata = m_pdata; m_apts = m_ppts; m_ablk = m_pblk;
         end
         m_pend = 1'b0;
      end
      if (bus.load) begin
         m_pdata = bus.data; m_ppts = bus.points; m_pblk = bus.blank;
         m_pend = 1'b1;
      end
      e.pending = m_pend;
      exp_q.push_back(e);
      tm++;
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_clear();
         else model_step();
      end
   end

   initial begin
      outs_t e, a;
      forever begin
         @(negedge clk);
         if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.an, bus.hex, bus.le, bus.point, bus.pending, bus.frame_done};
            chk("outs{an,hex,le,point,pending,frame_done}", 32'(a), 32'(e));
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, ".an"},         32'(bus.an),         32'hFF);
      chk({tag, ".hex"},        32'(bus.hex),        32'h0);
      chk({tag, ".le"},         32'(bus.le),         32'h1);
      chk({tag, ".point"},      32'(bus.point),      32'h0);
      chk({tag, ".pending"},    32'(bus.pending),    32'h0);
      chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'h0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
      bus.load = 1'b1; bus.data = d; bus.points = p; bus.blank = b;
      step();
      bus.load = 1'b0;
   endtask

   // Advance until the next edge processed by the model is frame position target.
   task automatic wait_pos(input int target);
      for (int i = 0; i < 2 * FRAME && (tm % FRAME) != target; i++) step();
      chk("align", 32'(tm % FRAME), 32'(target));
   endtask

   initial begin
      logic [31:0] d;
      rst_n = 1'b1;
      bus.load = 1'b0; bus.data = '0; bus.points = '0; bus.blank = '0; bus.lz_en = 1'b0;
      #1 rst_n = 1'b0;
      #1 chk_reset("reset");
      #20 rst_n = 1'b1;
      step();

      // Full hex pattern across every digit.
      do_load(32'h89ABCDEF, 8'h00, 8'h00);
      repeat (3 * FRAME) step();

      // Leading-zero suppression.
      bus.lz_en = 1'b1;
      do_load(32'h00000120, 8'h00, 8'h00);
      repeat (2 * FRAME + 5) step();

      // Second load within a frame overwrites the first.
      wait_pos(3);
      do_load(32'h11111111, 8'h00, 8'h00);
      repeat (5) step();
      do_load(32'h22222222, 8'h00, 8'h00);
      repeat (2 * FRAME) step();

      // Load coinciding with the commit cycle.
      wait_pos(2);
      do_load(32'h0000A5A5, 8'h00, 8'h00);
      wait_pos(FRAME - 1);
      do_load(32'h5A5A0000, 8'h00, 8'h00);
      repeat (2 * FRAME + 3) step();

      // Blanked top digit and decimal point on digit 0.
      bus.lz_en = 1'b0;
      do_load(32'h12345678, 8'h01, 8'h80);
      repeat (2 * FRAME) step();

      // Mid-slot reset on digit 5 with an uncommitted load in flight.
      do_load(32'hCAFEF00D, 8'hFF, 8'h00);
      wait_pos(5 * SD + 2);
      #2 rst_n = 1'b0;
      #1 chk_reset("midslot_reset");
      #14 rst_n = 1'b1;
      step();
      repeat (FRAME + 4) step();

      // Randomized traffic with occasional asynchronous resets.
      for (int it = 0; it < 60; it++) begin
         repeat ($urandom_range(0, 40)) step();
         if ($urandom_range(0, 3) == 0) bus.lz_en = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       d = $urandom;
            1:       d = $urandom >> (4 * $urandom_range(1, 7));
            2:       d = 32'h0;
            default: d = $urandom & 32'h00F0_0F0F;
         endcase
         do_load(d, 8'($urandom), ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00);
         if ($urandom_range(0, 19) == 0) begin
            #3 rst_n = 1'b0;
            #1 chk_reset("rand_reset");
            #7 rst_n = 1'b1;
            step();
         end
      end
      repeat (FRAME) step();

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
